// File: rtl/store_unit_pkg.sv
// Shared types for the store path: the instruction word layout, store size
// encodings and the store FSM states.
package store_unit_pkg;

    // Store access sizes carried in funct3 of an S-type instruction
    localparam logic [2:0] F3_SB = 3'd0;
    localparam logic [2:0] F3_SH = 3'd1;
    localparam logic [2:0] F3_SW = 3'd2;

    typedef struct packed {
        logic [6:0] imm_hi;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] imm_lo;
        logic [6:0] opcode;
    } s_type_t;

    typedef union packed {
        logic [31:0] raw;
        s_type_t     S;
    } instr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ0,
        ST_REQ1,
        ST_DONE,
        ST_ERR
    } st_state_e;

endpackage

// File: rtl/store_unit_aligner.sv
// Combinational lane aligner: spreads a store of 1/2/NB bytes across a
// double-width window so a misaligned store can be split into two words.
module store_unit_aligner
    import store_unit_pkg::*;
#(
    parameter  int DWIDTH = 32,
    localparam int NB     = DWIDTH / 8,
    localparam int OFFW   = $clog2(NB)
) (
    input  logic [2:0]          funct3_i,
    input  logic [OFFW-1:0]     off_i,
    input  logic [DWIDTH-1:0]   data_i,
    output logic [2*NB-1:0]     be2_o,
    output logic [2*DWIDTH-1:0] data2_o,
    output logic                size_ok_o
);

    logic [NB-1:0] mask;

    // Decode the access size into a byte mask; unknown sizes produce no lanes
    always_comb begin
        mask      = '0;
        size_ok_o = 1'b1;
        case (funct3_i)
            F3_SB:   mask = NB'(1);
            F3_SH:   mask = NB'(3);
            F3_SW:   mask = '1;
            default: size_ok_o = 1'b0;
        endcase
    end

    // Low half feeds the base word, high half the following word
    assign be2_o   = {{NB{1'b0}}, mask} << off_i;
    assign data2_o = {{DWIDTH{1'b0}}, data_i} << {off_i, 3'b000};

endmodule

// File: rtl/store_unit.sv
// Store unit: turns sb/sh/sw into one or two word-aligned write requests
// on a req/gnt memory port, splitting stores that cross a word boundary.
module store_unit
    import store_unit_pkg::*;
#(
    parameter  int DWIDTH = 32,
    parameter  int AWIDTH = 32,
    localparam int NB     = DWIDTH / 8,
    localparam int OFFW   = $clog2(NB)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  instr_t            instr,
    input  logic [AWIDTH-1:0] st_addr,
    input  logic [DWIDTH-1:0] st_data,
    output logic              st_done,
    output logic              st_err,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [NB-1:0]     mem_be,
    output logic [DWIDTH-1:0] mem_wdata
);

    st_state_e           state_q;
    logic                st_ready_q, st_done_q, st_err_q, mem_req_q;
    logic [AWIDTH-1:0]   mem_addr_q;
    logic [NB-1:0]       mem_be_q;
    logic [DWIDTH-1:0]   mem_wdata_q;

    // Second-word transaction captured at accept time
    logic [NB-1:0]       hi_be_q;
    logic [DWIDTH-1:0]   hi_wdata_q;
    logic                split_q;

    logic [2*NB-1:0]     be2;
    logic [2*DWIDTH-1:0] data2;
    logic                size_ok;
    logic                accept;

    assign accept = st_valid && st_ready_q;

    store_unit_aligner #(.DWIDTH(DWIDTH)) u_aligner (
        .funct3_i  (instr.S.funct3),
        .off_i     (st_addr[OFFW-1:0]),
        .data_i    (st_data),
        .be2_o     (be2),
        .data2_o   (data2),
        .size_ok_o (size_ok)
    );

    // Hold the upper-word half of the store until the first request is granted
    always_ff @(posedge clk) begin
        if (accept) begin
            hi_be_q    <= be2[2*NB-1:NB];
            hi_wdata_q <= data2[2*DWIDTH-1:DWIDTH];
            split_q    <= |be2[2*NB-1:NB];
        end
    end

    // Store FSM with registered handshake and memory-port outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            st_ready_q  <= 1'b1;
            st_done_q   <= 1'b0;
            st_err_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        st_ready_q <= 1'b0;
                        if (size_ok) begin
                            state_q     <= ST_REQ0;
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= {st_addr[AWIDTH-1:OFFW], {OFFW{1'b0}}};
                            mem_be_q    <= be2[NB-1:0];
                            mem_wdata_q <= data2[DWIDTH-1:0];
                        end else begin
                            state_q   <= ST_ERR;
                            st_done_q <= 1'b1;
                            st_err_q  <= 1'b1;
                        end
                    end
                end
                ST_REQ0: begin
                    if (mem_gnt) begin
                        if (split_q) begin
                            state_q     <= ST_REQ1;
                            mem_addr_q  <= mem_addr_q + AWIDTH'(NB);
                            mem_be_q    <= hi_be_q;
                            mem_wdata_q <= hi_wdata_q;
                        end else begin
                            state_q   <= ST_DONE;
                            mem_req_q <= 1'b0;
                            st_done_q <= 1'b1;
                        end
                    end
                end
                ST_REQ1: begin
                    if (mem_gnt) begin
                        state_q   <= ST_DONE;
                        mem_req_q <= 1'b0;
                        st_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    st_done_q  <= 1'b0;
                    st_err_q   <= 1'b0;
                    st_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign st_ready  = st_ready_q;
    assign st_done   = st_done_q;
    assign st_err    = st_err_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_store_unit.sv
// Randomized bench for store_unit with a byte-level reference model.
module tb_store_unit;
    import store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    instr_t      instr;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        st_done, st_err;
    logic        mem_req;
    logic        mem_gnt = 1'b0;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;

    int n_chk  = 0;
    int n_pass = 0;

    store_unit #(.DWIDTH(32), .AWIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .instr     (instr),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_done   (st_done),
        .st_err    (st_err),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One store through the unit; stall0/stall1 are grant-withheld cycles
    // for the first and second request, busy drives junk requests meanwhile.
    task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                            input int stall0, input int stall1, input bit busy);
        logic [7:0]  be_full;
        logic [63:0] full;
        logic [31:0] e_ad [2];
        logic [3:0]  e_be [2];
        logic [31:0] e_wd [2];
        int          ntx, size, off, s;

        // Reference: walk the stored bytes and place each in its word lane
        be_full = '0;
        size    = 1 << f3;
        off     = int'(a % 4);
        if (f3 <= 3'd2)
            for (int i = 0; i < size; i++) be_full[off + i] = 1'b1;
        full    = {32'b0, d} << (8 * off);
        e_be[0] = be_full[3:0];
        e_be[1] = be_full[7:4];
        e_wd[0] = full[31:0];
        e_wd[1] = full[63:32];
        e_ad[0] = a & ~32'd3;
        e_ad[1] = e_ad[0] + 32'd4;
        ntx     = (e_be[1] != 4'd0) ? 2 : 1;

        check("ready_before", st_ready, 1);
        instr.raw       = $urandom;
        instr.S.funct3  = f3;
        st_addr         = a;
        st_data         = d;
        st_valid        = 1'b1;
        tick();
        st_valid = 1'b0;

        if (f3 > 3'd2) begin
            check("err_done", st_done, 1);
            check("err_flag", st_err, 1);
            check("err_noreq", mem_req, 0);
            tick();
            check("err_ready", st_ready, 1);
            check("err_done_clr", st_done, 0);
            check("err_noreq2", mem_req, 0);
            return;
        end

        for (int t = 0; t < ntx; t++) begin
            s = (t == 0) ? stall0 : stall1;
            for (int c = 0; c <= s; c++) begin
                mem_gnt = (c == s);
                if (busy) begin
                    st_valid       = 1'($urandom_range(0, 1));
                    instr.raw      = $urandom;
                    instr.S.funct3 = 3'($urandom_range(0, 2));
                    st_addr        = $urandom;
                    st_data        = $urandom;
                end
                check("req", mem_req, 1);
                check("req_nodone", st_done, 0);
                check("req_busy", st_ready, 0);
                check("addr", mem_addr, e_ad[t]);
                check("be", mem_be, e_be[t]);
                check("wdata", mem_wdata, e_wd[t]);
                tick();
            end
        end
        mem_gnt  = 1'b0;
        st_valid = 1'b0;
        check("done", st_done, 1);
        check("done_noerr", st_err, 0);
        check("done_noreq", mem_req, 0);
        tick();
        check("ready_after", st_ready, 1);
        check("done_clr", st_done, 0);
        check("idle_noreq", mem_req, 0);
    endtask

    initial begin
        instr.raw = '0;
        #2 rst = 1'b1;
        #2;
        check("rst_ready", st_ready, 1);
        check("rst_done", st_done, 0);
        check("rst_err", st_err, 0);
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_be", mem_be, 0);
        check("rst_wdata", mem_wdata, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Directed cases
        do_store(F3_SW, 32'h100, 32'hDEADBEEF, 0, 0, 1'b0);
        do_store(F3_SB, 32'h203, 32'h000000A5, 0, 0, 1'b0);
        do_store(F3_SH, 32'h303, 32'h00001234, 0, 0, 1'b0);
        do_store(F3_SW, 32'h102, 32'hCAFEF00D, 3, 3, 1'b1);
        do_store(3'd3, 32'h400, 32'h11111111, 0, 0, 1'b0);
        do_store(F3_SB, 32'h7FF, 32'h89ABCDEF, 1, 0, 1'b0);

        // Reset while the second half of a split store is pending
        check("rst_mid_ready", st_ready, 1);
        instr.raw      = $urandom;
        instr.S.funct3 = F3_SH;
        st_addr        = 32'h303;
        st_data        = 32'h00005678;
        st_valid       = 1'b1;
        tick();
        st_valid = 1'b0;
        mem_gnt  = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("rst_mid_req1", mem_req, 1);
        check("rst_mid_addr1", mem_addr, 32'h304);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_dropreq", mem_req, 0);
        check("rst_mid_nodone", st_done, 0);
        tick();
        check("rst_mid_nodone2", st_done, 0);
        rst = 1'b0;
        tick();
        check("rst_mid_ready_after", st_ready, 1);
        check("rst_mid_idle", mem_req, 0);
        check("rst_mid_nodone3", st_done, 0);

        // Random stores, mostly legal sizes with an occasional bad funct3
        for (int k = 0; k < 60; k++) begin
            int          r;
            logic [2:0]  f3;
            r  = $urandom_range(0, 9);
            f3 = (r < 8) ? 3'(r % 3) : 3'($urandom_range(3, 7));
            do_store(f3, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
                     1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
Store-side counterpart of the load extender. Takes a store instruction (sb/sh/sw) with its effective address and rs2 data. Produces word-aligned memory write transactions with byte enables and lane-shifted write data. A store that crosses a word boundary is split into two sequential transactions on a req/gnt memory port. Sits between the execute stage and the data memory write port; the core stalls on st_ready low.

Parameters:
DWIDTH, 32, data and memory word width in bits; multiple of 8, at least 16
AWIDTH, 32, byte address width
NB, DWIDTH/8, bytes per word (localparam, derived)
OFFW, $clog2(NB), byte-offset bits (localparam, derived)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
st_valid  input  1  store request valid
st_ready  output  1  unit idle, can accept a request
instr  input  instr_t  store instruction; instr.S.funct3 selects the access size
st_addr  input  AWIDTH  effective byte address
st_data  input  DWIDTH  rs2 value; low bytes are used for sb/sh
st_done  output  1  one-cycle pulse: store complete (or rejected)
st_err  output  1  one-cycle pulse with st_done: unsupported funct3
mem_req  output  1  memory write request
mem_gnt  input  1  memory accepts the current request
mem_addr  output  AWIDTH  word-aligned address (low OFFW bits are 0)
mem_be  output  NB  byte enables
mem_wdata  output  DWIDTH  lane-aligned write data

Behaviour:
- Reset values: state IDLE; st_ready=1; st_done=0; st_err=0; mem_req=0; mem_addr=0; mem_be=0; mem_wdata=0. Reset asserted mid-transaction drops mem_req immediately and discards the store. No st_done is produced.
- Accept: when st_valid && st_ready on a rising edge, the unit registers instr funct3, st_addr and st_data. st_valid while st_ready=0 is ignored. The requester must not assume it was queued.
- Alignment, with off = st_addr[OFFW-1:0]:
  - size mask: sb=1, sh=2'b11, sw=all NB ones.
  - Full 2*NB enable vector = mask << off. Full 2*DWIDTH data vector = zero-extended st_data << (8*off).
  - Low half of each vector forms transaction 0 at the base word address, st_addr with the low OFFW bits cleared.
  - High half of each vector forms transaction 1 at base+NB. Transaction 1 exists only if the high half of the enable vector is nonzero.
- Unsupported funct3 (anything other than 0, 1, 2): no memory access. st_done=1 and st_err=1 in the cycle after acceptance, then IDLE.
- States:
  - IDLE: st_ready=1. On accept, go to REQ0, or to ERR for an unsupported funct3.
  - REQ0: mem_req=1 with transaction 0 outputs. On mem_gnt, go to REQ1 if split, else DONE.
  - REQ1: mem_req=1 with transaction 1 outputs. On mem_gnt, go to DONE.
  - DONE / ERR: st_done=1 (st_err=1 in ERR). Next cycle go to IDLE.
- Handshake: mem_addr, mem_be and mem_wdata are registered and held stable while mem_req=1 and mem_gnt=0. A grant takes effect only in the cycle where mem_req && mem_gnt. mem_gnt while mem_req=0 is ignored. mem_be and mem_wdata may hold stale values when mem_req=0.
- Latency, accept at cycle N:
  - aligned store with immediate grant: mem_req at N+1, st_done at N+2.
  - split store with immediate grants: st_done at N+3.
  - Each stalled grant cycle adds one cycle.
- Back-to-back: st_ready returns to 1 the cycle after st_done, so the minimum spacing is 3 cycles for an aligned store.
- Misaligned halfword/word stores are supported, not trapped. The memory must tolerate two sequential writes.

Decomposition:
- typedefs_pkg: store funct3 constants (F3_SB=0, F3_SH=1, F3_SW=2) and the store FSM state enum. Reuse the existing instr_t.
- Sub-module store_aligner (combinational): funct3, offset and data in; 2*NB enable vector, 2*DWIDTH data vector and a valid-size flag out. Unit-tested separately.

Test Plan:
- sw addr=0x100, data=0xDEADBEEF, gnt tied 1 -> one req: addr=0x100, be=1111, wdata=0xDEADBEEF; st_done at N+2, st_err=0.
- sb addr=0x203, data=0x000000A5 -> one req: addr=0x200, be=1000, wdata[31:24]=0xA5.
- sh addr=0x303, data=0x1234 -> req0: addr=0x300, be=1000, wdata[31:24]=0x34; req1: addr=0x304, be=0001, wdata[7:0]=0x12; st_done at N+3.
- sw addr=0x102 with gnt withheld 3 cycles per request -> addr/be/wdata stable during the wait; be=1100 then 0011; st_done at N+9; st_valid pulses while busy are ignored.
- funct3=3 -> no mem_req; st_done=st_err=1 at N+1; st_ready=1 at N+2.
- rst raised while in REQ1 -> mem_req=0 immediately, st_done never pulses, st_ready=1 after release.
